// File: rtl/enc16_4_evt.sv
// 16-line rising-edge event encoder: latches each request rise as a pending event
// and streams the highest-priority pending line index out over valid/ready.
module enc16_4_evt #(
  parameter bit PRIO_HIGH = 1'b1,
  parameter bit PREV_RST  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d,
  output logic [3:0]  code,
  output logic        code_valid,
  input  logic        code_ready,
  output logic [4:0]  pend_cnt,
  output logic        ovf,
  input  logic        ovf_clr
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [15:0] prev_q;
  logic [15:0] pend_q, pend_d;
  logic [3:0]  code_q, code_d;
  logic        ovf_q, ovf_d;

  logic [15:0] rise;
  logic [15:0] load_clr;
  logic [3:0]  sel;
  logic        load;

  assign rise = d & ~prev_q;

  // Later iterations overwrite earlier ones, so loop direction sets priority.
  always_comb begin
    sel = 4'd0;
    if (PRIO_HIGH) begin
      for (int i = 0; i < 16; i++)
        if (pend_q[i]) sel = 4'(i);
    end else begin
      for (int i = 15; i >= 0; i--)
        if (pend_q[i]) sel = 4'(i);
    end
  end

  always_comb begin
    pend_cnt = 5'd0;
    for (int i = 0; i < 16; i++)
      pend_cnt = pend_cnt + 5'(pend_q[i]);
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    load     = 1'b0;
    load_clr = 16'h0000;
    case (state_q)
      IDLE: begin
        if (pend_q != 16'h0000) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (code_ready) begin
          if (pend_q != 16'h0000) load = 1'b1;
          else                    state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      code_d        = sel;
      load_clr[sel] = 1'b1;
    end
    // A rise on the line being loaded this cycle re-arms it as a second event.
    pend_d = (pend_q & ~load_clr) | rise;
    if (|(rise & pend_q & ~load_clr)) ovf_d = 1'b1;
    else if (ovf_clr)                 ovf_d = 1'b0;
    else                              ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= {16{PREV_RST}};
      pend_q  <= 16'h0000;
      code_q  <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  assign code       = code_q;
  assign code_valid = (state_q == HOLD);
  assign ovf        = ovf_q;

endmodule
